// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - FSM state encodings shared by the serial add/subtract datapaths
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_1b.sv
// rtl/full_subtractor_1b.sv - combinational 1-bit full subtractor cell
module full_subtractor_1b (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b, LSB first, one bit per clock
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] result;
    logic             bff;
    logic [CNT_W-1:0] cnt;
    logic             d_bit;
    logic             b_out;

    full_subtractor_1b u_fs (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (bff),
        .d    (d_bit),
        .bout (b_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Result bits enter at the MSB, so after WIDTH shifts bit 0 holds the first difference bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            result <= '0;
            bff    <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        bff <= 1'b0;
                        cnt <= '0;
                    end
                end
                ST_RUN: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    result <= {d_bit, result[WIDTH-1:1]};
                    bff    <= b_out;
                    cnt    <= cnt + CNT_W'(1);
                end
                ST_DONE: begin
                    done   <= 1'b1;
                    diff   <= result;
                    borrow <= bff;
                    zero   <= (result == '0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and randomized checks of serial_subtractor
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            n++;
            if (done === 1'b1) return;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, output int lat);
        a     = va;
        b     = vb;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
    endtask

    initial begin
        int lat;
        int ndone;
        logic busy_pre;
        logic busy_at;
        logic prev_busy;
        logic [WIDTH-1:0] ea;
        logic [WIDTH-1:0] eb;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        check("rst_zero", zero, 0);

        // 1: 100 - 37, latency counted in edges after the accepting edge
        a = 8'd100; b = 8'd37; start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy_run", busy, 1);
        lat = 1;
        wait_done(ndone);
        lat += ndone;
        check("t1_latency", lat, WIDTH + 2);
        check("t1_diff", diff, 63);
        check("t1_borrow", borrow, 0);
        check("t1_zero", zero, 0);
        check("t1_busy_done_cycle", busy, 0);
        tick();
        check("t1_done_pulse", done, 0);
        check("t1_diff_hold", diff, 63);

        // 2: 5 - 9 wraps
        run_op(8'd5, 8'd9, lat);
        check("t2_latency", lat, WIDTH + 1);
        check("t2_diff", diff, 252);
        check("t2_borrow", borrow, 1);
        check("t2_zero", zero, 0);

        // 3: zero result, then ff - 01
        run_op(8'd0, 8'd0, lat);
        check("t3a_diff", diff, 0);
        check("t3a_borrow", borrow, 0);
        check("t3a_zero", zero, 1);
        run_op(8'hFF, 8'h01, lat);
        check("t3b_diff", diff, 8'hFE);
        check("t3b_borrow", borrow, 0);
        check("t3b_zero", zero, 0);

        // 4: start pulse during RUN is ignored
        a = 8'd10; b = 8'd3; start = 1'b1;
        tick();
        start     = 1'b0;
        ndone     = 0;
        busy_pre  = 1'b0;
        busy_at   = 1'b1;
        prev_busy = busy;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 3) begin
                start = 1'b1; a = 8'd200; b = 8'd1;
            end
            if (k == 4) start = 1'b0;
            if (done === 1'b1) begin
                if (ndone == 0) begin
                    busy_pre = prev_busy;
                    busy_at  = busy;
                end
                ndone++;
            end
            prev_busy = busy;
        end
        check("t4_done_count", ndone, 1);
        check("t4_diff", diff, 7);
        check("t4_busy_in_done_state", busy_pre, 1);
        check("t4_busy_after_done", busy_at, 0);

        // 5: reset on the third RUN cycle aborts the operation
        a = 8'd50; b = 8'd20; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_diff", diff, 0);
        check("t5_borrow", borrow, 0);
        check("t5_zero", zero, 0);
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        check("t5_no_done", ndone, 0);
        run_op(8'd50, 8'd20, lat);
        check("t5_rerun_diff", diff, 30);
        check("t5_rerun_borrow", borrow, 0);

        // 6: start held high, new random operands at every done
        ea    = 8'($urandom_range(0, 255));
        eb    = 8'($urandom_range(0, 255));
        a     = ea;
        b     = eb;
        start = 1'b1;
        for (int i = 0; i < 500; i++) begin
            wait_done(lat);
            if (i > 0) check("t6_spacing", lat, WIDTH + 2);
            check("t6_diff", diff, 32'(8'(ea - eb)));
            check("t6_borrow", borrow, 32'(ea < eb));
            ea = 8'($urandom_range(0, 255));
            eb = 8'($urandom_range(0, 255));
            a  = ea;
            b  = eb;
        end
        start = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
